sr_latch_driver: RTL and testbench



---
 rtl/sr_latch_driver.sv | 174 +++++++++++++++++
 tb/tb_sr_latch_driver.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_driver.sv
// Command stage for a gated NAND SR latch: synchronizes and debounces
// set/clear requests, then sequences clean s/r levels around an en pulse.
module sr_latch_driver #(
    parameter int DEBOUNCE  = 4,
    parameter int EN_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic s,
    output logic r,
    output logic en,
    output logic busy,
    output logic done,
    output logic q_exp
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int PW = $clog2(EN_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        RELEASE
    } state_t;

    // Bit 0 carries the set line, bit 1 the clear line.
    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    lvl;
    logic [1:0]    lvl_d;
    logic [CW-1:0] cnt [2];
    logic [1:0]    evt;

    assign raw = {clr_req, set_req};
    assign evt = lvl & ~lvl_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            lvl_d <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            lvl_d <= lvl;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == lvl[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE - 1)) begin
                    lvl[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    state_t        state;
    state_t        state_next;
    logic          pend_vld;
    logic          pend_clr;
    logic          cmd_clr;
    logic          take;
    logic          kind_next;
    logic [PW-1:0] pcnt;

    assign take      = (state == IDLE) && pend_vld;
    assign kind_next = take ? pend_clr : cmd_clr;

    // A fresh event wins over consumption so it is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld <= 1'b0;
            pend_clr <= 1'b0;
            cmd_clr  <= 1'b0;
        end else begin
            if (evt != 2'b00) begin
                pend_vld <= 1'b1;
                pend_clr <= evt[1];
            end else if (take) begin
                pend_vld <= 1'b0;
            end
            if (take) begin
                cmd_clr <= pend_clr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pcnt  <= '0;
        end else begin
            state <= state_next;
            if (state == PULSE) begin
                pcnt <= pcnt + PW'(1);
            end else begin
                pcnt <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (pend_vld) state_next = SETUP;
            SETUP:   state_next = PULSE;
            PULSE:   if (pcnt == PW'(EN_CYCLES - 1)) state_next = HOLD;
            HOLD:    state_next = RELEASE;
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    logic s_n;
    logic r_n;
    logic en_n;
    logic busy_n;
    logic done_n;
    logic q_n;

    // Outputs are decoded from the next state so every port is a flop.
    always_comb begin
        s_n    = 1'b1;
        r_n    = 1'b1;
        en_n   = 1'b0;
        busy_n = 1'b0;
        done_n = 1'b0;
        q_n    = q_exp;
        unique case (state_next)
            SETUP, PULSE, HOLD: begin
                s_n    = kind_next;
                r_n    = ~kind_next;
                en_n   = (state_next == PULSE);
                busy_n = 1'b1;
            end
            RELEASE: begin
                busy_n = 1'b1;
                done_n = 1'b1;
                q_n    = ~kind_next;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s     <= 1'b1;
            r     <= 1'b1;
            en    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            q_exp <= 1'b0;
        end else begin
            s     <= s_n;
            r     <= r_n;
            en    <= en_n;
            busy  <= busy_n;
            done  <= done_n;
            q_exp <= q_n;
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Randomized and directed bench for sr_latch_driver against a
// command-timeline reference model.
module tb_sr_latch_driver;

    localparam int DEB = 4;
    localparam int ENC = 2;

    logic clk = 1'b0;
    logic rst;
    logic set_req;
    logic clr_req;
    logic s;
    logic r;
    logic en;
    logic busy;
    logic done;
    logic q_exp;

    always #5 clk = ~clk;

    sr_latch_driver #(
        .DEBOUNCE (DEB),
        .EN_CYCLES(ENC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .set_req(set_req),
        .clr_req(clr_req),
        .s      (s),
        .r      (r),
        .en     (en),
        .busy   (busy),
        .done   (done),
        .q_exp  (q_exp)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got,
                             input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, want, $time);
        end
    endtask

    // Reference: raw -> 2-stage sync -> debounce run -> rising event ->
    // one-deep pending slot -> command timeline indexed by cycle offset.
    bit m_r1 [2];
    bit m_sy [2];
    bit m_lv [2];
    int m_run [2];
    bit m_ev [2];
    bit m_pv;
    bit m_pk;
    bit m_act;
    int m_off;
    bit m_kind;
    bit m_q;
    bit prev_en;
    bit [1:0] prev_sr;

    task automatic model_edge(input bit sr, input bit cr, input bit rs);
        bit raw [2];
        bit take;
        bit old_lv;
        raw[0] = sr;
        raw[1] = cr;
        take = 1'b0;
        if (rs) begin
            for (int i = 0; i < 2; i++) begin
                m_r1[i] = 0; m_sy[i] = 0; m_lv[i] = 0;
                m_run[i] = 0; m_ev[i] = 0;
            end
            m_pv = 0; m_pk = 0; m_act = 0; m_off = 0;
            m_kind = 0; m_q = 0;
        end else begin
            if (m_act) begin
                if (m_off == ENC + 2) m_act = 0;
                else m_off++;
            end else if (m_pv) begin
                m_act = 1; m_off = 0; m_kind = m_pk; take = 1;
            end
            if (m_act && m_off == ENC + 2) m_q = !m_kind;
            if (m_ev[0] || m_ev[1]) begin
                m_pv = 1;
                m_pk = m_ev[1];
            end else if (take) begin
                m_pv = 0;
            end
            for (int i = 0; i < 2; i++) begin
                old_lv = m_lv[i];
                if (m_sy[i] != m_lv[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB) begin
                        m_lv[i] = m_sy[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
                m_ev[i] = m_lv[i] && !old_lv;
                m_sy[i] = m_r1[i];
                m_r1[i] = raw[i];
            end
        end
    endtask

    task automatic check_outputs(input bit rs);
        bit es, er, ee, eb, ed;
        es = !(m_act && m_off <= ENC + 1 && !m_kind);
        er = !(m_act && m_off <= ENC + 1 && m_kind);
        ee = m_act && m_off >= 1 && m_off <= ENC;
        eb = m_act;
        ed = m_act && m_off == ENC + 2;
        expect_eq("outs", {s, r, en, busy, done, q_exp},
                  {es, er, ee, eb, ed, m_q});
        expect_eq("sr_excl", s | r, 1);
        if (prev_en && !rs) expect_eq("sr_hold_en", {s, r}, prev_sr);
        prev_en = en;
        prev_sr = {s, r};
        if (done === 1'b1) n_done++;
    endtask

    task automatic step(input bit sr, input bit cr, input bit rs);
        set_req = sr;
        clr_req = cr;
        rst = rs;
        @(posedge clk);
        model_edge(sr, cr, rs);
        @(negedge clk);
        check_outputs(rs);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0);
    endtask

    initial begin
        int k;
        int base;
        int hold;
        bit rsr, rcr, rrs;

        step($urandom_range(0, 1), $urandom_range(0, 1), 1);
        step($urandom_range(0, 1), $urandom_range(0, 1), 1);
        expect_eq("reset_state", {s, r, en, busy, done, q_exp}, 6'b110000);
        idle(5);

        k = 0;
        do begin
            step(1, 0, 0);
            k++;
        end while (s !== 1'b0 && k < 40);
        expect_eq("set_latency", k - 1, 7);
        repeat (6) step(1, 0, 0);
        expect_eq("set_q_exp", q_exp, 1);
        idle(20);

        base = n_done;
        for (int p = 0; p < 2; p++) begin
            repeat (3) step(1, 0, 0);
            repeat (3) step(0, 0, 0);
        end
        idle(10);
        expect_eq("bounce_none", n_done - base, 0);
        repeat (6) step(1, 0, 0);
        idle(20);
        expect_eq("bounce_then_set", n_done - base, 1);

        base = n_done;
        repeat (10) step(1, 1, 0);
        idle(25);
        expect_eq("simul_cmds", n_done - base, 1);
        expect_eq("simul_q_exp", q_exp, 0);

        repeat (3) step(1, 0, 0);
        idle(20);
        base = n_done;
        step(1, 0, 0);
        step(1, 0, 0);
        repeat (10) step(1, 1, 0);
        idle(30);
        expect_eq("busy_queue_cmds", n_done - base, 2);
        expect_eq("busy_queue_q", q_exp, 0);

        repeat (3) step(1, 0, 0);
        idle(20);
        base = n_done;
        step(1, 0, 0);
        step(1, 0, 0);
        k = 0;
        while (en !== 1'b1 && k < 30) begin
            step(1, 1, 0);
            k++;
        end
        expect_eq("mid_pulse_seen", en, 1);
        step(0, 0, 1);
        expect_eq("mid_reset", {s, r, en, busy, done, q_exp}, 6'b110000);
        idle(30);
        expect_eq("mid_no_pending", n_done - base, 0);

        hold = 0;
        rsr = 0;
        rcr = 0;
        for (int i = 0; i < 2000; i++) begin
            if (hold == 0) begin
                rsr = 1'($urandom_range(0, 1));
                rcr = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 10);
            end
            hold--;
            rrs = ($urandom_range(0, 299) == 0);
            step(rsr, rcr, rrs);
        end
        idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
